// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, opcode/funct constants, MD sequencer states and decode helpers
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_XOR     = 4'b0011,
    ALU_NOR     = 4'b0100,
    ALU_SUB     = 4'b0110,
    ALU_SLT     = 4'b0111,
    ALU_SRL     = 4'b1000,
    ALU_SLL     = 4'b1001,
    ALU_SRA     = 4'b1010,
    ALU_SLTU    = 4'b1011,
    ALU_MULSTEP = 4'b1100,
    ALU_DIVSTEP = 4'b1101,
    ALU_MFHI    = 4'b1110,
    ALU_MFLO    = 4'b1111
  } alu_ctrl_e;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_AND   = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_XOR   = 3'b110;
  localparam logic [2:0] ALUOP_ILL   = 3'b111;

  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_SRA   = 6'b000011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // mult/multu/div/divu share the 0110xx funct pattern
  function automatic logic is_md_op(input logic [5:0] funct);
    return funct[5:2] == 4'b0110;
  endfunction

  function automatic logic funct_defined(input logic [5:0] funct);
    case (funct)
      FUNCT_SLL, FUNCT_SRL, FUNCT_SRA, FUNCT_MFHI, FUNCT_MFLO,
      FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
      FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_XOR,
      FUNCT_NOR, FUNCT_SLT, FUNCT_SLTU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/aludec_mc_if.sv
// rtl/aludec_mc_if.sv - decode/MD-control bundle between main decoder and aludec_mc (ALUDEC_ILLEGAL_EN adds illegal flags)
interface aludec_mc_if #(
  parameter int CTRL_W = 4
) ();

  logic              valid_i;
  logic [2:0]        aluop;
  logic [5:0]        funct;
  logic [CTRL_W-1:0] alucontrol;
  logic              stall;
  logic              md_start;
  logic              md_busy;
  logic              md_is_div;
  logic              md_signed;
  logic [CTRL_W-1:0] md_ctrl;
  logic              hilo_we;
`ifdef ALUDEC_ILLEGAL_EN
  logic              illegal_o;
  logic              illegal_seen_o;

  modport master (
    output valid_i, aluop, funct,
    input  alucontrol, stall, md_start, md_busy, md_is_div, md_signed, md_ctrl, hilo_we,
    input  illegal_o, illegal_seen_o
  );

  modport slave (
    input  valid_i, aluop, funct,
    output alucontrol, stall, md_start, md_busy, md_is_div, md_signed, md_ctrl, hilo_we,
    output illegal_o, illegal_seen_o
  );
`else
  modport master (
    output valid_i, aluop, funct,
    input  alucontrol, stall, md_start, md_busy, md_is_div, md_signed, md_ctrl, hilo_we
  );

  modport slave (
    input  valid_i, aluop, funct,
    output alucontrol, stall, md_start, md_busy, md_is_div, md_signed, md_ctrl, hilo_we
  );
`endif

endinterface

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - IDLE/BUSY/DONE sequencer that times a mult/div op and strobes the HI/LO write
module md_sequencer
  import alu_pkg::*;
#(
  parameter int CTRL_W    = 4,
  parameter int MD_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              start_div,
  input  logic              start_signed,
  output logic              idle,
  output logic              busy,
  output logic              done,
  output logic              is_div,
  output logic              is_signed,
  output logic [CTRL_W-1:0] md_ctrl
);

  localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

  md_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic is_div_q, is_div_nxt;
  logic signed_q, signed_nxt;
  alu_ctrl_e step;

  // state, counter and latched op kind; reset aborts any op in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div_q <= 1'b0;
      signed_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      is_div_q <= is_div_nxt;
      signed_q <= signed_nxt;
    end
  end

  // next state: BUSY lasts MD_CYCLES-1 cycles so hilo_we lands MD_CYCLES after md_start
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    is_div_nxt = is_div_q;
    signed_nxt = signed_q;
    busy       = 1'b0;
    done       = 1'b0;
    step       = ALU_ADD;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = BUSY;
          cnt_nxt    = CW'(MD_CYCLES - 1);
          is_div_nxt = start_div;
          signed_nxt = start_signed;
        end
      end
      BUSY: begin
        busy    = 1'b1;
        step    = is_div_q ? ALU_DIVSTEP : ALU_MULSTEP;
        cnt_nxt = cnt - CW'(1);
        if (cnt_nxt == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign idle      = (state == IDLE);
  assign is_div    = is_div_q;
  assign is_signed = signed_q;
  assign md_ctrl   = CTRL_W'(step);

endmodule

// File: rtl/aludec_mc.sv
// rtl/aludec_mc.sv - ALU control decoder with mult/div interlock; ALUDEC_ILLEGAL_EN adds illegal_o/illegal_seen_o
module aludec_mc
  import alu_pkg::*;
#(
  parameter int CTRL_W    = 4,
  parameter int MD_CYCLES = 32
) (
  input logic        clk,
  input logic        reset_n,
  aludec_mc_if.slave bus
);

  alu_ctrl_e code;
  logic rtype;
  logic md_op;
  logic hilo_rd;
  logic seq_idle;
  logic issue;

  assign rtype   = (bus.aluop == ALUOP_RTYPE);
  assign md_op   = rtype && is_md_op(bus.funct);
  assign hilo_rd = rtype && (bus.funct == FUNCT_MFHI || bus.funct == FUNCT_MFLO);

  // anything touching HI/LO waits while the MD unit is still working, including its write-back cycle
  assign bus.stall    = bus.valid_i && (md_op || hilo_rd) && !seq_idle;
  assign issue        = bus.valid_i && md_op && seq_idle;
  assign bus.md_start = issue;

  // ALU code decode; MD ops, illegal codes and bubbles all fall back to ADD
  always_comb begin
    code = ALU_ADD;
    case (bus.aluop)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_OR:  code = ALU_OR;
      ALUOP_AND: code = ALU_AND;
      ALUOP_SLT: code = ALU_SLT;
      ALUOP_XOR: code = ALU_XOR;
      ALUOP_RTYPE: begin
        case (bus.funct)
          FUNCT_ADD:  code = ALU_ADD;
          FUNCT_SUB:  code = ALU_SUB;
          FUNCT_AND:  code = ALU_AND;
          FUNCT_OR:   code = ALU_OR;
          FUNCT_XOR:  code = ALU_XOR;
          FUNCT_NOR:  code = ALU_NOR;
          FUNCT_SLT:  code = ALU_SLT;
          FUNCT_SLTU: code = ALU_SLTU;
          FUNCT_SLL:  code = ALU_SLL;
          FUNCT_SRL:  code = ALU_SRL;
          FUNCT_SRA:  code = ALU_SRA;
          FUNCT_MFHI: code = ALU_MFHI;
          FUNCT_MFLO: code = ALU_MFLO;
          default:    code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
    if (!bus.valid_i) code = ALU_ADD;
  end

  assign bus.alucontrol = CTRL_W'(code);

  md_sequencer #(
    .CTRL_W    (CTRL_W),
    .MD_CYCLES (MD_CYCLES)
  ) u_md_sequencer (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (issue),
    .start_div    (bus.funct == FUNCT_DIV || bus.funct == FUNCT_DIVU),
    .start_signed (bus.funct == FUNCT_MULT || bus.funct == FUNCT_DIV),
    .idle         (seq_idle),
    .busy         (bus.md_busy),
    .done         (bus.hilo_we),
    .is_div       (bus.md_is_div),
    .is_signed    (bus.md_signed),
    .md_ctrl      (bus.md_ctrl)
  );

`ifdef ALUDEC_ILLEGAL_EN
  logic seen_q;

  assign bus.illegal_o = bus.valid_i &&
                         (bus.aluop == ALUOP_ILL || (rtype && !funct_defined(bus.funct)));

  // sticky record of any illegal instruction since reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) seen_q <= 1'b0;
    else if (bus.illegal_o) seen_q <= 1'b1;
  end

  assign bus.illegal_seen_o = seen_q;
`endif

endmodule

// File: tb/tb_aludec_mc.sv
// tb/tb_aludec_mc.sv - randomized and directed bench for aludec_mc (ALUDEC_ILLEGAL_EN adds illegal checks)
module tb_aludec_mc;

  localparam int MDC = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  aludec_mc_if #(.CTRL_W(4)) bus ();
  aludec_mc_if #(.CTRL_W(4)) bus2 ();

  aludec_mc #(.CTRL_W(4), .MD_CYCLES(MDC)) u_dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  aludec_mc #(.CTRL_W(4), .MD_CYCLES(2)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  int total = 0;
  int bad = 0;
  int cyc = 0;

  bit         cur_v;
  logic [2:0] cur_op;
  logic [5:0] cur_f;

  // reference MD unit: one op issued at cycle m_t owns HI/LO for cycles m_t+1 .. m_t+MDC
  bit m_pend = 0;
  int m_t = 0;
  bit m_div = 0;
  bit m_sgn = 0;

  function automatic logic [3:0] ref_code(bit v, logic [2:0] op, logic [5:0] f);
    if (!v) return 4'h2;
    case (op)
      3'd0: return 4'h2;
      3'd1: return 4'h6;
      3'd3: return 4'h1;
      3'd4: return 4'h0;
      3'd5: return 4'h7;
      3'd6: return 4'h3;
      3'd2: begin
        case (f)
          6'h20: return 4'h2;
          6'h22: return 4'h6;
          6'h24: return 4'h0;
          6'h25: return 4'h1;
          6'h26: return 4'h3;
          6'h27: return 4'h4;
          6'h2a: return 4'h7;
          6'h2b: return 4'hb;
          6'h00: return 4'h9;
          6'h02: return 4'h8;
          6'h03: return 4'ha;
          6'h10: return 4'he;
          6'h12: return 4'hf;
          default: return 4'h2;
        endcase
      end
      default: return 4'h2;
    endcase
  endfunction

  function automatic bit is_md(logic [5:0] f);
    return f == 6'h18 || f == 6'h19 || f == 6'h1a || f == 6'h1b;
  endfunction

  function automatic bit is_hr(logic [5:0] f);
    return f == 6'h10 || f == 6'h12;
  endfunction

  function automatic bit occupied();
    return m_pend && (cyc > m_t) && (cyc <= m_t + MDC);
  endfunction

  task automatic drive(bit v, logic [2:0] op, logic [5:0] f);
    cur_v = v; cur_op = op; cur_f = f;
    bus.valid_i = v; bus.aluop = op; bus.funct = f;
  endtask

  task automatic drive2(bit v, logic [2:0] op, logic [5:0] f);
    bus2.valid_i = v; bus2.aluop = op; bus2.funct = f;
  endtask

  task automatic tick();
    if (cur_v && cur_op == 3'd2 && is_md(cur_f) && !occupied()) begin
      m_pend = 1; m_t = cyc;
      m_div = (cur_f == 6'h1a || cur_f == 6'h1b);
      m_sgn = (cur_f == 6'h18 || cur_f == 6'h1a);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(0, 3'd0, 6'h0);
    drive2(0, 3'd0, 6'h0);
    reset_n = 1'b0;
    repeat (3) tick();
    #1;
    total++; if (bus.alucontrol !== 4'h2) begin bad++; $display("FAIL reset_alucontrol: got %0h want 2", bus.alucontrol); end
    total++; if (bus.md_ctrl !== 4'h2) begin bad++; $display("FAIL reset_md_ctrl: got %0h want 2", bus.md_ctrl); end
    total++; if ({bus.stall, bus.md_start, bus.md_busy, bus.md_is_div, bus.md_signed, bus.hilo_we} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000", {bus.stall, bus.md_start, bus.md_busy, bus.md_is_div, bus.md_signed, bus.hilo_we});
    end
`ifdef ALUDEC_ILLEGAL_EN
    total++; if (bus.illegal_seen_o !== 1'b0) begin bad++; $display("FAIL reset_illegal_seen: got %b want 0", bus.illegal_seen_o); end
`endif
    reset_n = 1'b1;
    tick();
  endtask

`ifdef ALUDEC_ILLEGAL_EN
  task automatic test_illegal();
    drive(1, 3'd0, 6'h0); #1;
    total++; if (bus.illegal_o !== 1'b0) begin bad++; $display("FAIL ill_legal_add: got %b want 0", bus.illegal_o); end
    tick();
    drive(1, 3'd7, 6'h20); #1;
    total++; if (bus.illegal_o !== 1'b1) begin bad++; $display("FAIL ill_aluop7: got %b want 1", bus.illegal_o); end
    tick();
    drive(0, 3'd0, 6'h0); #1;
    total++; if (bus.illegal_o !== 1'b0) begin bad++; $display("FAIL ill_pulse_end: got %b want 0", bus.illegal_o); end
    total++; if (bus.illegal_seen_o !== 1'b1) begin bad++; $display("FAIL ill_seen_sticky: got %b want 1", bus.illegal_seen_o); end
    tick();
    drive(1, 3'd2, 6'h3f); #1;
    total++; if (bus.illegal_o !== 1'b1) begin bad++; $display("FAIL ill_funct3f: got %b want 1", bus.illegal_o); end
    total++; if (bus.alucontrol !== 4'h2) begin bad++; $display("FAIL ill_funct3f_code: got %0h want 2", bus.alucontrol); end
    tick();
    drive(1, 3'd2, 6'h20); repeat (3) tick(); #1;
    total++; if (bus.illegal_seen_o !== 1'b1) begin bad++; $display("FAIL ill_seen_hold: got %b want 1", bus.illegal_seen_o); end
    drive(0, 3'd0, 6'h0);
    tick();
  endtask
`endif

  task automatic test_decode();
    logic [5:0] fl [15];
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h21, 6'h3f};
    for (int op = 0; op < 8; op++) begin
      if (op == 2) continue;
      drive(1, 3'(op), 6'(($urandom & 32'h3f))); #1;
      if (is_md(cur_f)) cur_f = 6'h20;
      drive(1, 3'(op), cur_f); #1;
      total++; if (bus.alucontrol !== ref_code(1, cur_op, cur_f)) begin
        bad++; $display("FAIL decode_aluop%0d: got %0h want %0h", op, bus.alucontrol, ref_code(1, cur_op, cur_f));
      end
      tick();
    end
    foreach (fl[i]) begin
      drive(1, 3'd2, fl[i]); #1;
      total++; if (bus.alucontrol !== ref_code(1, 3'd2, fl[i])) begin
        bad++; $display("FAIL decode_funct%0h: got %0h want %0h", fl[i], bus.alucontrol, ref_code(1, 3'd2, fl[i]));
      end
      tick();
    end
    drive(0, 3'd2, 6'h27); #1;
    total++; if (bus.alucontrol !== 4'h2) begin bad++; $display("FAIL decode_invalid: got %0h want 2", bus.alucontrol); end
    tick();
  endtask

  task automatic test_mult_latency();
    int pulses = 0;
    drive(1, 3'd2, 6'h18); #1;
    total++; if (bus.md_start !== 1'b1) begin bad++; $display("FAIL mult_start: got %b want 1", bus.md_start); end
    total++; if (bus.alucontrol !== 4'h2) begin bad++; $display("FAIL mult_issue_code: got %0h want 2", bus.alucontrol); end
    tick();
    drive(0, 3'd0, 6'h0);
    for (int k = 1; k <= MDC + 3; k++) begin
      #1;
      if (bus.hilo_we === 1'b1) pulses++;
      total++; if (bus.md_busy !== (k < MDC)) begin bad++; $display("FAIL mult_busy_k%0d: got %b want %b", k, bus.md_busy, k < MDC); end
      total++; if (bus.hilo_we !== (k == MDC)) begin bad++; $display("FAIL mult_hilo_k%0d: got %b want %b", k, bus.hilo_we, k == MDC); end
      total++; if (bus.md_ctrl !== ((k < MDC) ? 4'hc : 4'h2)) begin bad++; $display("FAIL mult_md_ctrl_k%0d: got %0h", k, bus.md_ctrl); end
      if (k == 2) begin
        total++; if (bus.md_signed !== 1'b1 || bus.md_is_div !== 1'b0) begin
          bad++; $display("FAIL mult_kind: got signed=%b div=%b want 1 0", bus.md_signed, bus.md_is_div);
        end
      end
      tick();
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL mult_hilo_count: got %0d want 1", pulses); end
  endtask

  task automatic test_mflo_interlock();
    int acc = -1;
    drive(1, 3'd2, 6'h1b); tick();
    drive(0, 3'd0, 6'h0);
    repeat (4) tick();
    for (int k = 5; k < 105; k++) begin
      drive(1, 3'd2, 6'h12); #1;
      total++; if (bus.stall !== (k <= MDC)) begin bad++; $display("FAIL mflo_stall_k%0d: got %b want %b", k, bus.stall, k <= MDC); end
      if (bus.stall !== 1'b1) begin
        acc = k;
        total++; if (bus.alucontrol !== 4'hf) begin bad++; $display("FAIL mflo_code: got %0h want f", bus.alucontrol); end
        total++; if (bus.md_is_div !== 1'b1 || bus.md_signed !== 1'b0) begin
          bad++; $display("FAIL divu_kind: got div=%b signed=%b want 1 0", bus.md_is_div, bus.md_signed);
        end
        tick();
        break;
      end
      tick();
    end
    total++; if (acc != MDC + 1) begin bad++; $display("FAIL mflo_accept_cycle: got %0d want %0d", acc, MDC + 1); end
    drive(0, 3'd0, 6'h0);
    tick();
  endtask

  task automatic test_busy_nonmd();
    drive(1, 3'd2, 6'h18); tick();
    drive(1, 3'd2, 6'h20); #1;
    total++; if (bus.stall !== 1'b0 || bus.alucontrol !== 4'h2) begin bad++; $display("FAIL busy_add: got stall=%b code=%0h want 0 2", bus.stall, bus.alucontrol); end
    tick();
    drive(1, 3'd1, 6'h0); #1;
    total++; if (bus.stall !== 1'b0 || bus.alucontrol !== 4'h6) begin bad++; $display("FAIL busy_sub: got stall=%b code=%0h want 0 6", bus.stall, bus.alucontrol); end
    tick();
    drive(1, 3'd3, 6'h0); #1;
    total++; if (bus.stall !== 1'b0 || bus.alucontrol !== 4'h1) begin bad++; $display("FAIL busy_or: got stall=%b code=%0h want 0 1", bus.stall, bus.alucontrol); end
    tick();
    drive(1, 3'd2, 6'h18); #1;
    total++; if (bus.stall !== 1'b1 || bus.md_start !== 1'b0) begin bad++; $display("FAIL busy_mult2: got stall=%b start=%b want 1 0", bus.stall, bus.md_start); end
    total++; if (bus.alucontrol !== 4'h2) begin bad++; $display("FAIL busy_mult2_code: got %0h want 2", bus.alucontrol); end
    drive(0, 3'd0, 6'h0);
    repeat (MDC + 2) tick();
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    drive(1, 3'd2, 6'h1a); tick();
    drive(0, 3'd0, 6'h0);
    repeat (9) tick();
    #1;
    total++; if (bus.md_busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before: got %b want 1", bus.md_busy); end
    reset_n = 1'b0; #1;
    m_pend = 0; m_div = 0; m_sgn = 0;
    total++; if (bus.md_busy !== 1'b0 || bus.hilo_we !== 1'b0 || bus.md_is_div !== 1'b0) begin
      bad++; $display("FAIL abort_immediate: got busy=%b hilo=%b div=%b want 0 0 0", bus.md_busy, bus.hilo_we, bus.md_is_div);
    end
    total++; if (bus.md_ctrl !== 4'h2) begin bad++; $display("FAIL abort_md_ctrl: got %0h want 2", bus.md_ctrl); end
    repeat (2) tick();
    reset_n = 1'b1;
    for (int k = 0; k < MDC + 5; k++) begin
      #1;
      if (bus.hilo_we === 1'b1) pulses++;
      tick();
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL abort_no_hilo: got %0d want 0", pulses); end
    drive(1, 3'd2, 6'h19); #1;
    total++; if (bus.md_start !== 1'b1) begin bad++; $display("FAIL abort_restart: got %b want 1", bus.md_start); end
    tick();
    drive(0, 3'd0, 6'h0);
    repeat (MDC - 1) tick();
    #1;
    total++; if (bus.hilo_we !== 1'b1 || bus.md_signed !== 1'b0) begin
      bad++; $display("FAIL abort_restart_done: got hilo=%b signed=%b want 1 0", bus.hilo_we, bus.md_signed);
    end
    repeat (2) tick();
  endtask

  task automatic test_md2();
    drive2(1, 3'd2, 6'h18); #1;
    total++; if (bus2.md_start !== 1'b1) begin bad++; $display("FAIL md2_start: got %b want 1", bus2.md_start); end
    tick();
    drive2(1, 3'd2, 6'h10); #1;
    total++; if (bus2.stall !== 1'b1 || bus2.md_busy !== 1'b1 || bus2.hilo_we !== 1'b0) begin
      bad++; $display("FAIL md2_t1: got stall=%b busy=%b hilo=%b want 1 1 0", bus2.stall, bus2.md_busy, bus2.hilo_we);
    end
    tick(); #1;
    total++; if (bus2.stall !== 1'b1 || bus2.md_busy !== 1'b0 || bus2.hilo_we !== 1'b1) begin
      bad++; $display("FAIL md2_t2: got stall=%b busy=%b hilo=%b want 1 0 1", bus2.stall, bus2.md_busy, bus2.hilo_we);
    end
    tick(); #1;
    total++; if (bus2.stall !== 1'b0 || bus2.hilo_we !== 1'b0 || bus2.alucontrol !== 4'he) begin
      bad++; $display("FAIL md2_t3: got stall=%b hilo=%b code=%0h want 0 0 e", bus2.stall, bus2.hilo_we, bus2.alucontrol);
    end
    drive2(0, 3'd0, 6'h0);
    tick();
  endtask

  task automatic test_random();
    logic [5:0] pool [10];
    bit v, occ, e_stall, e_start, e_busy, e_hilo;
    logic [2:0] op;
    logic [5:0] f;
    logic [3:0] e_ctrl;
    pool = '{6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h12, 6'h20, 6'h27, 6'h03, 6'h2b};
    for (int n = 0; n < 700; n++) begin
      v  = ($urandom_range(0, 9) > 2);
      op = ($urandom_range(0, 9) < 6) ? 3'd2 : 3'($urandom_range(0, 7));
      f  = ($urandom_range(0, 7) == 0) ? 6'($urandom & 32'h3f) : pool[$urandom_range(0, 9)];
      drive(v, op, f); #1;
      occ     = occupied();
      e_stall = v && op == 3'd2 && (is_md(f) || is_hr(f)) && occ;
      e_start = v && op == 3'd2 && is_md(f) && !occ;
      e_busy  = m_pend && cyc > m_t && cyc < m_t + MDC;
      e_hilo  = m_pend && cyc == m_t + MDC;
      e_ctrl  = e_busy ? (m_div ? 4'hd : 4'hc) : 4'h2;
      total++; if (bus.alucontrol !== ref_code(v, op, f)) begin bad++; $display("FAIL rnd_code n=%0d: got %0h want %0h", n, bus.alucontrol, ref_code(v, op, f)); end
      total++; if (bus.stall !== e_stall) begin bad++; $display("FAIL rnd_stall n=%0d: got %b want %b", n, bus.stall, e_stall); end
      total++; if (bus.md_start !== e_start) begin bad++; $display("FAIL rnd_start n=%0d: got %b want %b", n, bus.md_start, e_start); end
      total++; if (bus.md_busy !== e_busy) begin bad++; $display("FAIL rnd_busy n=%0d: got %b want %b", n, bus.md_busy, e_busy); end
      total++; if (bus.hilo_we !== e_hilo) begin bad++; $display("FAIL rnd_hilo n=%0d: got %b want %b", n, bus.hilo_we, e_hilo); end
      total++; if (bus.md_ctrl !== e_ctrl) begin bad++; $display("FAIL rnd_md_ctrl n=%0d: got %0h want %0h", n, bus.md_ctrl, e_ctrl); end
      total++; if (bus.md_is_div !== m_div || bus.md_signed !== m_sgn) begin
        bad++; $display("FAIL rnd_kind n=%0d: got div=%b signed=%b want %b %b", n, bus.md_is_div, bus.md_signed, m_div, m_sgn);
      end
      tick();
    end
    drive(0, 3'd0, 6'h0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
`ifdef ALUDEC_ILLEGAL_EN
    test_illegal();
`endif
    test_decode();
    test_mult_latency();
    test_mflo_interlock();
    test_busy_nonmd();
    test_reset_abort();
    test_md2();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
